// File: rtl/bfloat_minmax_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfloat_minmax_tracker_pkg
// Description : Shared state encoding, bfloat16 field constants and NaN test
//               for the min/max tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package bfloat_minmax_tracker_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0]  EXP_MAX   = 8'hFF;
   localparam logic [15:0] CANON_NAN = 16'h7FC0;

   function automatic logic is_nan(input logic [15:0] v);
      return (v[14:7] == EXP_MAX) && (v[6:0] != 7'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bfloat_minmax_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : bfloat_minmax_tracker_if
// Description : Element input stream and frame-result output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface bfloat_minmax_tracker_if #(
   parameter int IDX_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_max;
   logic [15:0]      out_min;
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_min_idx;
   logic [IDX_W:0]   out_count;
   logic             out_nan;
   logic             out_trunc;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx,
             out_count, out_nan, out_trunc
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx,
             out_count, out_nan, out_trunc
   );
endinterface
`default_nettype wire

// File: rtl/bfloat_minmax_tracker_cmp.sv
`default_nettype none
// ============================================================================
// Module      : bfloat_order_cmp
// Description : Numeric bfloat16 ordering of two non-NaN values.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat_order_cmp (
   input  wire logic [15:0] a,
   input  wire logic [15:0] b,
   output logic             a_gt_b,
   output logic             a_lt_b
);
   // Map to an unsigned key: negatives inverted, positives offset above them;
   // -0 folds onto +0 so the two compare equal.
   function automatic logic [15:0] order_key(input logic [15:0] v);
      logic [15:0] n;
      n = (v == 16'h8000) ? 16'h0000 : v;
      return n[15] ? ~n : (n | 16'h8000);
   endfunction

   logic [15:0] w_key_a;
   logic [15:0] w_key_b;

   assign w_key_a = order_key(a);
   assign w_key_b = order_key(b);
   assign a_gt_b  = (w_key_a > w_key_b);
   assign a_lt_b  = (w_key_a < w_key_b);

endmodule
`default_nettype wire

// File: rtl/bfloat_minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bfloat_minmax_tracker
// Description : Per-frame max/min (with positions), count and NaN tracking of
//               a bfloat16 element stream.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat_minmax_tracker
   import bfloat_minmax_tracker_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input wire logic                clk,
   input wire logic                rst,
   bfloat_minmax_tracker_if.slave  bus
);
   localparam int MAX_LEN = 2**IDX_W;

   state_t           r_state,   w_state_nxt;
   logic [15:0]      r_max,     w_max_nxt;
   logic [15:0]      r_min,     w_min_nxt;
   logic [IDX_W-1:0] r_max_idx, w_max_idx_nxt;
   logic [IDX_W-1:0] r_min_idx, w_min_idx_nxt;
   logic [IDX_W:0]   r_count,   w_count_nxt;
   logic             r_nan,     w_nan_nxt;
   logic             r_trunc,   w_trunc_nxt;

   logic             w_accept;
   logic             w_in_nan;
   logic             w_len_end;
   logic             w_gt_max;
   logic             w_lt_min;
   logic             w_unused_gt;
   logic             w_unused_lt;
   logic [IDX_W-1:0] w_idx;

   bfloat_order_cmp u_cmp_max (
      .a      (bus.in_data),
      .b      (r_max),
      .a_gt_b (w_gt_max),
      .a_lt_b (w_unused_lt)
   );

   bfloat_order_cmp u_cmp_min (
      .a      (bus.in_data),
      .b      (r_min),
      .a_gt_b (w_unused_gt),
      .a_lt_b (w_lt_min)
   );

   assign w_accept  = bus.in_valid && (r_state != ST_HOLD);
   assign w_in_nan  = is_nan(bus.in_data);
   assign w_idx     = r_count[IDX_W-1:0];
   assign w_len_end = (r_count == (IDX_W+1)'(MAX_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_EMPTY;
         r_max     <= '0;
         r_min     <= '0;
         r_max_idx <= '0;
         r_min_idx <= '0;
         r_count   <= '0;
         r_nan     <= 1'b0;
         r_trunc   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_max     <= w_max_nxt;
         r_min     <= w_min_nxt;
         r_max_idx <= w_max_idx_nxt;
         r_min_idx <= w_min_idx_nxt;
         r_count   <= w_count_nxt;
         r_nan     <= w_nan_nxt;
         r_trunc   <= w_trunc_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_max_nxt     = r_max;
      w_min_nxt     = r_min;
      w_max_idx_nxt = r_max_idx;
      w_min_idx_nxt = r_min_idx;
      w_count_nxt   = r_count;
      w_nan_nxt     = r_nan;
      w_trunc_nxt   = r_trunc;
      case (r_state)
         ST_EMPTY, ST_ACCUM: begin
            if (w_accept) begin
               w_count_nxt = r_count + {{IDX_W{1'b0}}, 1'b1};
               if (w_in_nan) begin
                  w_nan_nxt = 1'b1;
                  // An all-NaN frame reports the canonical NaN at index 0.
                  if (r_state == ST_EMPTY) begin
                     w_max_nxt     = CANON_NAN;
                     w_min_nxt     = CANON_NAN;
                     w_max_idx_nxt = '0;
                     w_min_idx_nxt = '0;
                  end
               end else if (r_state == ST_EMPTY) begin
                  w_max_nxt     = bus.in_data;
                  w_min_nxt     = bus.in_data;
                  w_max_idx_nxt = w_idx;
                  w_min_idx_nxt = w_idx;
                  w_state_nxt   = ST_ACCUM;
               end else begin
                  if (w_gt_max) begin
                     w_max_nxt     = bus.in_data;
                     w_max_idx_nxt = w_idx;
                  end
                  if (w_lt_min) begin
                     w_min_nxt     = bus.in_data;
                     w_min_idx_nxt = w_idx;
                  end
               end
               if (bus.in_last || w_len_end) begin
                  w_state_nxt = ST_HOLD;
                  w_trunc_nxt = !bus.in_last;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               w_state_nxt   = ST_EMPTY;
               w_max_nxt     = '0;
               w_min_nxt     = '0;
               w_max_idx_nxt = '0;
               w_min_idx_nxt = '0;
               w_count_nxt   = '0;
               w_nan_nxt     = 1'b0;
               w_trunc_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   assign bus.in_ready    = (r_state != ST_HOLD);
   assign bus.out_valid   = (r_state == ST_HOLD);
   assign bus.out_max     = r_max;
   assign bus.out_min     = r_min;
   assign bus.out_max_idx = r_max_idx;
   assign bus.out_min_idx = r_min_idx;
   assign bus.out_count   = r_count;
   assign bus.out_nan     = r_nan;
   assign bus.out_trunc   = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_bfloat_minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfloat_minmax_tracker
// Description : Directed bench for the bfloat16 min/max tracker (IDX_W 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bfloat_minmax_tracker;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   bfloat_minmax_tracker_if #(.IDX_W(8)) a ();
   bfloat_minmax_tracker_if #(.IDX_W(2)) b ();

   bfloat_minmax_tracker #(.IDX_W(8)) u_dut_a (.clk(clk), .rst(rst), .bus(a.slave));
   bfloat_minmax_tracker #(.IDX_W(2)) u_dut_b (.clk(clk), .rst(rst), .bus(b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit sm, input logic [15:0] d, input logic l);
      int n;
      n = 0;
      if (sm) begin b.in_valid = 1'b1; b.in_data = d; b.in_last = l; end
      else    begin a.in_valid = 1'b1; a.in_data = d; a.in_last = l; end
      while (!(sm ? b.in_ready : a.in_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $error("FAIL send_timeout: observed in_ready 0 expected 1");
      end
      @(negedge clk);
      if (sm) b.in_valid = 1'b0;
      else    a.in_valid = 1'b0;
   endtask

   task automatic expect_res(input bit sm, input string tg,
                             input logic [15:0] mx, input logic [15:0] mn,
                             input int mxi, input int mni, input int cnt,
                             input logic nan, input logic tr);
      int n;
      n = 0;
      while (!(sm ? b.out_valid : a.out_valid) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tg, "_lat"},  n, 0);
      chk({tg, "_max"},  32'(sm ? b.out_max : a.out_max), 32'(mx));
      chk({tg, "_min"},  32'(sm ? b.out_min : a.out_min), 32'(mn));
      chk({tg, "_maxi"}, sm ? 32'(b.out_max_idx) : 32'(a.out_max_idx), mxi);
      chk({tg, "_mini"}, sm ? 32'(b.out_min_idx) : 32'(a.out_min_idx), mni);
      chk({tg, "_cnt"},  sm ? 32'(b.out_count) : 32'(a.out_count), cnt);
      chk({tg, "_nan"},  32'(sm ? b.out_nan : a.out_nan), 32'(nan));
      chk({tg, "_trunc"}, 32'(sm ? b.out_trunc : a.out_trunc), 32'(tr));
      if (sm) b.out_ready = 1'b1; else a.out_ready = 1'b1;
      @(negedge clk);
      if (sm) b.out_ready = 1'b0; else a.out_ready = 1'b0;
      chk({tg, "_drop"}, 32'(sm ? b.out_valid : a.out_valid), 0);
   endtask

   task automatic chk_zero(input string tg);
      chk({tg, "_vld"},  32'(a.out_valid), 0);
      chk({tg, "_rdy"},  32'(a.in_ready), 1);
      chk({tg, "_max"},  32'(a.out_max), 0);
      chk({tg, "_min"},  32'(a.out_min), 0);
      chk({tg, "_idx"},  32'({a.out_max_idx, a.out_min_idx}), 0);
      chk({tg, "_cnt"},  32'(a.out_count), 0);
      chk({tg, "_flag"}, 32'({a.out_nan, a.out_trunc}), 0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Mixed-sign frame
      send(0, 16'h3F80, 0); send(0, 16'hC000, 0); send(0, 16'h4040, 0); send(0, 16'h0000, 1);
      expect_res(0, "f1", 16'h4040, 16'hC000, 2, 1, 4, 0, 0);
      // Signed zeros tie; equal values keep earliest index
      send(0, 16'h8000, 0); send(0, 16'h0000, 1);
      expect_res(0, "zero", 16'h8000, 16'h8000, 0, 0, 2, 0, 0);
      send(0, 16'h4000, 0); send(0, 16'h4000, 1);
      expect_res(0, "tie", 16'h4000, 16'h4000, 0, 0, 2, 0, 0);
      // NaN handling
      send(0, 16'h7FC1, 0); send(0, 16'h3F80, 1);
      expect_res(0, "nan1", 16'h3F80, 16'h3F80, 1, 1, 2, 1, 0);
      send(0, 16'h7F81, 1);
      expect_res(0, "nanonly", 16'h7FC0, 16'h7FC0, 0, 0, 1, 1, 0);
      // Infinities and denormals
      send(0, 16'hFF80, 0); send(0, 16'h7F80, 1);
      expect_res(0, "inf", 16'h7F80, 16'hFF80, 1, 0, 2, 0, 0);
      send(0, 16'h0001, 0); send(0, 16'h8001, 0); send(0, 16'h0000, 1);
      expect_res(0, "denorm", 16'h0001, 16'h8001, 0, 1, 3, 0, 0);

      // Backpressure: result must hold while out_ready stays low
      send(0, 16'h3F80, 0); send(0, 16'hBF80, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rdy", 32'(a.in_ready), 0);
         chk("bp_vld", 32'(a.out_valid), 1);
         chk("bp_max", 32'(a.out_max), 32'h3F80);
         chk("bp_min", 32'(a.out_min), 32'hBF80);
         chk("bp_cnt", 32'(a.out_count), 2);
         @(negedge clk);
      end
      expect_res(0, "bp", 16'h3F80, 16'hBF80, 0, 1, 2, 0, 0);

      // Reset mid-frame discards the partial frame
      send(0, 16'h4000, 0); send(0, 16'hC000, 0);
      rst = 1'b1;
      #1;
      chk_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_novld", 32'(a.out_valid), 0);
      send(0, 16'h3F80, 1);
      expect_res(0, "after_rst", 16'h3F80, 16'h3F80, 0, 0, 1, 0, 0);

      // Reset during HOLD drops the pending result
      send(0, 16'h7FC1, 1);
      chk("hold_vld", 32'(a.out_valid), 1);
      rst = 1'b1;
      #1;
      chk_zero("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(0, 16'hC040, 1);
      expect_res(0, "after_hold", 16'hC040, 16'hC040, 0, 0, 1, 0, 0);

      // Small instance: MAX_LEN = 4 truncation, then 5th element is a new frame
      send(1, 16'h3F80, 0); send(1, 16'h4000, 0); send(1, 16'h4040, 0); send(1, 16'h4080, 0);
      expect_res(1, "trunc", 16'h4080, 16'h3F80, 3, 0, 4, 0, 1);
      send(1, 16'h40A0, 1);
      expect_res(1, "fifth", 16'h40A0, 16'h40A0, 0, 0, 1, 0, 0);
      // in_last on the MAX_LEN-th beat is not a truncation
      send(1, 16'hC000, 0); send(1, 16'h4000, 0); send(1, 16'hC000, 0); send(1, 16'h4000, 1);
      expect_res(1, "full_last", 16'h4000, 16'hC000, 1, 0, 4, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/bfloat_minmax_tracker.md
BFLOAT_MINMAX_TRACKER -- requirements
Module: bfloat_minmax_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter IDX_W SHALL default to 8 and set the element-index width; maximum frame length MAX_LEN = 2**IDX_W.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream element valid.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 in_data  input  16  bfloat16 element (sign[15], exp[14:7], mant[6:0]).
REQ-008 in_last  input  1  element is the last of its frame.
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_max, out_min  output  16 each  largest and smallest non-NaN element of the frame.
REQ-012 out_max_idx, out_min_idx  output  IDX_W each  zero-based frame position of out_max and out_min.
REQ-013 out_count  output  IDX_W+1  number of elements accepted in the frame.
REQ-014 out_nan  output  1  at least one NaN was seen in the frame.
REQ-015 out_trunc  output  1  frame was ended by MAX_LEN, not by in_last.

Function
REQ-016 States SHALL be EMPTY (no non-NaN element yet in the frame), ACCUM (at least one non-NaN element held) and HOLD (result presented).
REQ-017 An element SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 in EMPTY and ACCUM and 0 in HOLD.
REQ-018 Ordering SHALL be numeric bfloat16 order; +0 (0000) and -0 (8000) SHALL compare equal; infinities SHALL be ordinary values; denormals SHALL be compared by their bit magnitude.
REQ-019 NaN (exp = FF, mant != 0) SHALL NOT update max/min; it SHALL set the frame's nan flag and still increment the count.
REQ-020 The first non-NaN element SHALL load both max and min with its own index and move the state EMPTY -> ACCUM.
REQ-021 In ACCUM, max and its index SHALL be replaced only when the element is strictly greater; min and its index SHALL be replaced only when it is strictly smaller; ties SHALL keep the earlier index.
REQ-022 A frame SHALL end on an accepted beat with in_last = 1 or on the MAX_LEN-th accepted beat; out_trunc SHALL be 1 only in the second case without in_last.
REQ-023 On frame end, the state SHALL go to HOLD and out_valid SHALL rise the next cycle, giving one cycle of latency from the last beat; the result SHALL include the last element.
REQ-024 In HOLD, all out_* SHALL stay stable until out_valid and out_ready are both 1; the state SHALL then go to EMPTY and the frame registers SHALL clear in that cycle.
REQ-025 If a frame holds only NaNs, out_max and out_min SHALL be 7FC0, both indices SHALL be 0 and out_nan SHALL be 1.
REQ-026 out_valid SHALL be 0 outside HOLD; out_* data values SHALL be don't-care while out_valid is 0.

Reset
REQ-027 Asserting rst SHALL force the state to EMPTY, set in_ready to 1 and set out_valid, out_max, out_min, both indices, out_count, out_nan and out_trunc to 0.
REQ-028 A reset mid-frame or during HOLD SHALL discard the partial frame or pending result without emitting it.

Structure
REQ-029 A shared package SHALL hold the state enum, the bfloat16 field constants (EXP_MAX = 8'hFF, CANON_NAN = 16'h7FC0) and an is_nan function.
REQ-030 One combinational sub-module, bfloat_order_cmp, SHALL take inputs a and b and return a_gt_b and a_lt_b using the REQ-018 ordering; it SHALL be instantiated twice, once against max and once against min.

Verification
REQ-031 Frame 3F80, C000, 4040, 0000(last) -> out_max = 4040 with idx 2, out_min = C000 with idx 1, count 4, nan 0, trunc 0.
REQ-032 Frame 8000, 0000(last) -> max = min = 8000 with both indices 0; frame 4000, 4000(last) -> both indices 0.
REQ-033 Frame 7FC1, 3F80(last) -> max = min = 3F80 with idx 1, count 2, nan 1; frame 7F81(last) -> max = min = 7FC0, nan 1.
REQ-034 Frame FF80, 7F80(last) -> max = 7F80 (+inf) with idx 1, min = FF80 (-inf) with idx 0.
REQ-035 With IDX_W = 2, stream 5 elements without in_last -> first result after 4 beats with count 4 and trunc 1; the 5th element starts a new frame.
REQ-036 Backpressure and reset: hold out_ready at 0 for 5 cycles -> outputs stable and in_ready 0 throughout; assert rst after 2 beats of a frame -> no out_valid, all outputs 0, and the next frame is reported independently.
